mux16_rr_scheduler: RTL and testbench

MUX16_RR_SCHEDULER -- requirements
Module: mux16_rr_scheduler

---
 rtl/mux16_rr_scheduler_if.sv | 14 +
 rtl/mux16_rr_scheduler.sv | 115 +++++++++++
 tb/tb_mux16_rr_scheduler.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mux16_rr_scheduler_if.sv
// Request/grant bundle between a 16:1 mux round-robin scheduler and its requesters/consumer.
// Pure wiring: no latency; the consumer's only flow control is ack.
interface mux16_rr_scheduler_if;
   logic        en;
   logic [15:0] req;
   logic        ack;
   logic [3:0]  sel;
   logic [15:0] gnt;
   logic        gnt_valid;
   logic        timeout;

   modport master (output en, req, ack, input sel, gnt, gnt_valid, timeout);
   modport slave  (input en, req, ack, output sel, gnt, gnt_valid, timeout);
endinterface

// File: rtl/mux16_rr_scheduler.sv
// Round-robin grant scheduler driving a 16:1 mux select; grant appears 1 cycle after request in IDLE.
// Grant is held until ack, request withdrawal or TIMEOUT expiry, followed by one idle RELEASE cycle.
module mux16_rr_scheduler #(
   parameter int TIMEOUT = 15
) (
   input logic                  clk,
   input logic                  rst_n,
   mux16_rr_scheduler_if.slave  bus
);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW:0] TO_LIM = (CW + 1)'(TIMEOUT);

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;

   state_t        state, state_nxt;
   logic [3:0]    ptr, ptr_nxt;
   logic [3:0]    sel_q, sel_nxt;
   logic [3:0]    pick;
   logic          found;
   logic [15:0]   gnt_q, gnt_nxt;
   logic          gv_q, gv_nxt;
   logic          to_q, to_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          any_req, rel_ack, rel_wd, rel_to, release_g;

   assign any_req   = |bus.req;
   assign rel_ack   = bus.ack;
   assign rel_wd    = !bus.req[sel_q];
   // cnt holds completed grant cycles, so the current edge ends cycle cnt+1
   assign rel_to    = (TIMEOUT != 0) && (({1'b0, cnt} + 1'b1) == TO_LIM);
   assign release_g = (state == GRANT) && (rel_ack || rel_wd || rel_to);

   always_comb begin
      pick  = ptr;
      found = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (!found && bus.req[ptr + 4'(i)]) begin
            pick  = ptr + 4'(i);
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= 4'd0;
         sel_q <= 4'd0;
         gnt_q <= 16'h0;
         gv_q  <= 1'b0;
         to_q  <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         sel_q <= sel_nxt;
         gnt_q <= gnt_nxt;
         gv_q  <= gv_nxt;
         to_q  <= to_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.en && any_req) state_nxt = GRANT;
         GRANT:   if (release_g) state_nxt = RELEASE;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sel_nxt = sel_q;
      gnt_nxt = gnt_q;
      gv_nxt  = gv_q;
      to_nxt  = 1'b0;
      ptr_nxt = ptr;
      cnt_nxt = cnt;
      case (state)
         IDLE: begin
            if (bus.en && any_req) begin
               sel_nxt = pick;
               gnt_nxt = 16'h1 << pick;
               gv_nxt  = 1'b1;
               cnt_nxt = '0;
            end else begin
               gnt_nxt = 16'h0;
               gv_nxt  = 1'b0;
            end
         end
         GRANT: begin
            if (release_g) begin
               gnt_nxt = 16'h0;
               gv_nxt  = 1'b0;
               ptr_nxt = sel_q + 4'd1;
               // ack or withdrawal in the expiry cycle counts as a normal release
               to_nxt  = rel_to && !rel_ack && !rel_wd;
            end else begin
               cnt_nxt = (&cnt) ? cnt : cnt + 1'b1;
            end
         end
         default: begin
            gnt_nxt = 16'h0;
            gv_nxt  = 1'b0;
         end
      endcase
   end

   assign bus.sel       = sel_q;
   assign bus.gnt       = gnt_q;
   assign bus.gnt_valid = gv_q;
   assign bus.timeout   = to_q;
endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Self-checking bench for mux16_rr_scheduler built with TIMEOUT=3: cycle vector table plus reset sequence.
module tb_mux16_rr_scheduler;
   logic clk;
   logic rst_n;

   mux16_rr_scheduler_if bus();

   mux16_rr_scheduler #(.TIMEOUT(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic        en;
      logic [15:0] req;
      logic        ack;
      logic [3:0]  sel;
      logic        gv;
      logic        to;
   } vec_t;

   typedef struct {
      logic [3:0]  sel;
      logic [15:0] gnt;
      logic        gv;
      logic        to;
   } exp_t;

   vec_t vecs[$];
   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   function automatic vec_t mk(logic en, logic [15:0] req, logic ack,
                               logic [3:0] sel, logic gv, logic to);
      vec_t v;
      v.en = en; v.req = req; v.ack = ack; v.sel = sel; v.gv = gv; v.to = to;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input exp_t e);
      chk({tag, ".sel"},       32'(bus.sel),       32'(e.sel));
      chk({tag, ".gnt"},       32'(bus.gnt),       32'(e.gnt));
      chk({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(e.gv));
      chk({tag, ".timeout"},   32'(bus.timeout),   32'(e.to));
   endtask

   task automatic step(input vec_t v, input string tag);
      exp_t e;
      e.sel = v.sel;
      e.gv  = v.gv;
      e.to  = v.to;
      e.gnt = v.gv ? (16'h1 << v.sel) : 16'h0;
      sbq.push_back(e);
      bus.en  = v.en;
      bus.req = v.req;
      bus.ack = v.ack;
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         errors++;
         checks++;
         $display("FAIL %s.scoreboard: got empty queue required one entry", tag);
      end else begin
         chk_out(tag, sbq.pop_front());
      end
   endtask

   initial begin
      exp_t zero;
      zero.sel = 4'd0; zero.gnt = 16'h0; zero.gv = 1'b0; zero.to = 1'b0;

      //                en    req       ack   sel  gv    to
      // basic grant, ack release, next in order, en drop mid-grant, idle ack ignored
      vecs.push_back(mk(1'b1, 16'h0011, 1'b0, 4'd0,  1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0011, 1'b1, 4'd0,  1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0011, 1'b0, 4'd0,  1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0011, 1'b0, 4'd4,  1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 16'h0011, 1'b0, 4'd4,  1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 16'h0010, 1'b1, 4'd4,  1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 16'h0010, 1'b0, 4'd4,  1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 16'h0010, 1'b1, 4'd4,  1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0000, 1'b0, 4'd4,  1'b0, 1'b0));
      // ch14 then pointer at 15: ch15, wrap to ch0
      vecs.push_back(mk(1'b1, 16'h4000, 1'b0, 4'd14, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 16'hC001, 1'b1, 4'd14, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 16'h8001, 1'b0, 4'd14, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 16'h8001, 1'b0, 4'd15, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 16'h8001, 1'b1, 4'd15, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 16'h8001, 1'b0, 4'd15, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 16'h8001, 1'b0, 4'd0,  1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 16'h8001, 1'b1, 4'd0,  1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 4'd0,  1'b0, 1'b0));
      // forced release after 3 grant cycles, then ch2 skipped for ch5
      vecs.push_back(mk(1'b1, 16'h0004, 1'b0, 4'd2,  1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0024, 1'b0, 4'd2,  1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0024, 1'b0, 4'd2,  1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0024, 1'b0, 4'd2,  1'b0, 1'b1));
      vecs.push_back(mk(1'b1, 16'h0024, 1'b0, 4'd2,  1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0024, 1'b0, 4'd5,  1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0024, 1'b1, 4'd5,  1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 4'd5,  1'b0, 1'b0));
      // ack coincides with expiry: no timeout pulse
      vecs.push_back(mk(1'b1, 16'h0040, 1'b0, 4'd6,  1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0040, 1'b0, 4'd6,  1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0040, 1'b0, 4'd6,  1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0040, 1'b1, 4'd6,  1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 4'd6,  1'b0, 1'b0));
      // withdrawal on ch7, pointer moves to 8
      vecs.push_back(mk(1'b1, 16'h0080, 1'b0, 4'd7,  1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0000, 1'b0, 4'd7,  1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0000, 1'b0, 4'd7,  1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0181, 1'b0, 4'd8,  1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0181, 1'b1, 4'd8,  1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 4'd8,  1'b0, 1'b0));
      // withdrawal coincides with expiry: no timeout pulse
      vecs.push_back(mk(1'b1, 16'h0200, 1'b0, 4'd9,  1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0200, 1'b0, 4'd9,  1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0200, 1'b0, 4'd9,  1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0000, 1'b0, 4'd9,  1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 4'd9,  1'b0, 1'b0));
      // lone requester regranted every turn at 3-cycle spacing
      vecs.push_back(mk(1'b1, 16'h0008, 1'b0, 4'd3,  1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0008, 1'b1, 4'd3,  1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0008, 1'b0, 4'd3,  1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0008, 1'b0, 4'd3,  1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 16'h0008, 1'b1, 4'd3,  1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 4'd3,  1'b0, 1'b0));

      rst_n   = 1'b0;
      bus.en  = 1'b1;
      bus.req = 16'hFFFF;
      bus.ack = 1'b1;
      #2;
      chk_out("reset_async", zero);
      @(posedge clk);
      #1;
      chk_out("reset_held", zero);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_out("reset_release", zero);
      bus.en  = 1'b0;
      bus.req = 16'h0;
      bus.ack = 1'b0;
      @(posedge clk);
      #1;
      chk_out("reset_first_edge", zero);

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i], $sformatf("vec%0d", i));

      // asynchronous reset in the middle of a grant on ch9
      step(mk(1'b1, 16'h0200, 1'b0, 4'd9, 1'b1, 1'b0), "rst_grant9");
      bus.req = 16'hFFFF;
      #3;
      rst_n = 1'b0;
      #1;
      chk_out("rst_mid_grant", zero);
      @(posedge clk);
      #1;
      chk_out("rst_mid_held", zero);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_out("rst_mid_release", zero);
      step(mk(1'b1, 16'hFFFF, 1'b0, 4'd0, 1'b1, 1'b0), "post_rst_ch0");
      step(mk(1'b1, 16'hFFFF, 1'b1, 4'd0, 1'b0, 1'b0), "post_rst_ack");
      step(mk(1'b1, 16'hFFFF, 1'b0, 4'd0, 1'b0, 1'b0), "post_rst_release");
      step(mk(1'b1, 16'hFFFF, 1'b0, 4'd1, 1'b1, 1'b0), "post_rst_ch1");

      if (sbq.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL scoreboard_drain: got %0d leftover required 0", sbq.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
